// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the single-port main memory shared by fetch (0), execute (1) and I/O (2).
// Each access is a GRANT (memory strobe) cycle followed by a DONE (ack + read data) cycle.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 64,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              R,
    input  logic [2:0]        req,
    input  logic [2:0]        lock,
    input  logic [2:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        gnt,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    // Handshake: a requester raises req[i] with addr/we/wdata stable; gnt[i] marks ownership
    // once granted, and ack[i] pulses for one cycle when the access completes. A granted
    // access always completes (dropping req after grant does not cancel it).

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DONE = 2'd2} state_t;

    state_t        state, state_n;
    logic [1:0]    owner, owner_n;
    logic [1:0]    p, p_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [2:0]    win, win_rel;
    logic [1:0]    p_rel;
    logic          can_hold;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Returns {found, index}; candidates are scanned from last to first so the earliest wins.
    function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] ptr);
        logic [1:0] c0, c1, c2;
        logic [2:0] res;
        c0  = ptr;
        c1  = inc3(c0);
        c2  = inc3(c1);
        res = 3'b000;
        if (r[c2]) res = {1'b1, c2};
        if (r[c1]) res = {1'b1, c1};
        if (r[c0]) res = {1'b1, c0};
        return res;
    endfunction

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state    <= IDLE;
            owner    <= 2'd0;
            p        <= 2'd0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            p        <= p_n;
            hold_cnt <= hold_n;
        end
    end

    assign p_rel    = inc3(owner);
    assign win      = pick(req, p);
    assign win_rel  = pick(req, p_rel);
    assign can_hold = (32'(hold_cnt) < MAX_HOLD - 1);

    always_comb begin
        state_n = state;
        owner_n = owner;
        p_n     = p;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (win[2]) begin
                    state_n = GRANT;
                    owner_n = win[1:0];
                    hold_n  = '0;
                end
            end
            GRANT: state_n = DONE;
            DONE: begin
                if (lock[owner] && req[owner] && can_hold) begin
                    state_n = GRANT;
                    hold_n  = hold_cnt + HW'(1);
                end else begin
                    p_n = p_rel;
                    if (win_rel[2]) begin
                        state_n = GRANT;
                        owner_n = win_rel[1:0];
                        hold_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset clears them in the same cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        gnt       = 3'b000;
        ack       = 3'b000;
        rdata     = '0;
        busy      = (state != IDLE);
        fsm_state = state;
        if (state != IDLE) gnt = 3'b001 << owner;
        if (state == GRANT) begin
            mem_en = 1'b1;
            case (owner)
                2'd0:    begin mem_we = we[0]; mem_addr = addr0; mem_wdata = wdata0; end
                2'd1:    begin mem_we = we[1]; mem_addr = addr1; mem_wdata = wdata1; end
                default: begin mem_we = we[2]; mem_addr = addr2; mem_wdata = wdata2; end
            endcase
        end
        if (state == DONE) begin
            ack   = 3'b001 << owner;
            rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios push expected acks, a monitor pops them.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int EW = 3 + 1 + DW;  // {ack port, check data, data}

    localparam logic [DW-1:0] V0 = 64'h0000_0000_DEAD_BEEF;
    localparam logic [DW-1:0] V1 = 64'h1111_2222_3333_4444;
    localparam logic [DW-1:0] V2 = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [DW-1:0] WV = 64'h0123_4567_89AB_CDEF;

    logic          clk, R;
    logic [2:0]    req, lock, we;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [DW-1:0] wdata0, wdata1, wdata2;
    logic [DW-1:0] mem_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    gnt, ack;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [1:0]    fsm_state;

    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] mem_arr [0:255];
    int            n_checks = 0;
    int            n_errors = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut (
        .clk(clk), .R(R), .req(req), .lock(lock), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous memory model
    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = '0;
        mem_arr[8'h10] = V0;
        mem_arr[8'h11] = V1;
        mem_arr[8'h12] = V2;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr[7:0]];
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL idle_timeout: busy still %b after 50 cycles, expected 0", busy);
    endtask

    task automatic push_exp(input logic [2:0] port, input logic chk_data, input logic [DW-1:0] data);
        exp_q.push_back({port, chk_data, data});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (ack !== 3'b000) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got ack=%b, expected no ack", ack);
            end else begin
                e = exp_q.pop_front();
                chk("ack_port", DW'(ack), DW'(e[EW-1:EW-3]));
                if (e[DW]) chk("ack_rdata", rdata, e[DW-1:0]);
            end
        end
    end

    initial begin
        R = 1'b1; req = 3'b111; lock = 3'b000; we = 3'b000;
        addr0 = 16'h0010; addr1 = 16'h0011; addr2 = 16'h0012;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;

        // reset held with all ports requesting
        repeat (3) @(negedge clk);
        chk("rst_gnt", DW'(gnt), 0);
        chk("rst_ack", DW'(ack), 0);
        chk("rst_mem_en", DW'(mem_en), 0);
        chk("rst_mem_we", DW'(mem_we), 0);
        chk("rst_mem_addr", DW'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", DW'(busy), 0);
        chk("rst_state", DW'(fsm_state), 0);

        // first grant after release goes to port 0; single read of 0x0010
        push_exp(3'b001, 1'b1, V0);
        R = 1'b0;
        @(negedge clk);
        chk("rd_gnt", DW'(gnt), 3'b001);
        chk("rd_mem_en", DW'(mem_en), 1);
        chk("rd_mem_addr", DW'(mem_addr), 16'h0010);
        chk("rd_mem_we", DW'(mem_we), 0);
        chk("rd_state", DW'(fsm_state), 1);
        req = 3'b000;
        @(negedge clk);
        chk("rd_busy_done", DW'(busy), 1);
        @(negedge clk);
        chk("rd_gnt_release", DW'(gnt), 0);
        chk("rd_idle_busy", DW'(busy), 0);

        // round robin: pointer now at port 1
        push_exp(3'b010, 1'b1, V1);
        push_exp(3'b100, 1'b1, V2);
        push_exp(3'b001, 1'b1, V0);
        push_exp(3'b010, 1'b1, V1);
        req = 3'b111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_busy", DW'(busy), 1);
            if (i == 0) chk("rr_first_gnt", DW'(gnt), 3'b010);
            if (i == 6) req = 3'b000;
        end
        wait_idle();

        // lock bound: pointer at 2, port 0 locks for four transfers, then port 1
        for (int i = 0; i < 4; i++) push_exp(3'b001, 1'b1, V0);
        push_exp(3'b010, 1'b1, V1);
        req = 3'b011; lock = 3'b001;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i % 2 == 0 && i < 8) chk("lock_gnt_hold", DW'(gnt), 3'b001);
            if (i == 8) begin
                chk("lock_gnt_release", DW'(gnt), 3'b010);
                req = 3'b000; lock = 3'b000;
            end
        end
        wait_idle();

        // write from port 2, then read it back
        we = 3'b100; addr2 = 16'h00FF; wdata2 = WV;
        push_exp(3'b100, 1'b0, '0);
        req = 3'b100;
        @(negedge clk);
        chk("wr_mem_en", DW'(mem_en), 1);
        chk("wr_mem_we", DW'(mem_we), 1);
        chk("wr_mem_addr", DW'(mem_addr), 16'h00FF);
        chk("wr_mem_wdata", mem_wdata, WV);
        req = 3'b000;
        @(negedge clk);
        we = 3'b000;
        wait_idle();
        push_exp(3'b100, 1'b1, WV);
        req = 3'b100;
        @(negedge clk);
        chk("rb_mem_we", DW'(mem_we), 0);
        req = 3'b000;
        wait_idle();

        // reset during port 1 grant: transfer lost, no ack
        req = 3'b010;
        @(negedge clk);
        chk("mid_gnt", DW'(gnt), 3'b010);
        R = 1'b1;
        #1;
        chk("mid_rst_mem_en", DW'(mem_en), 0);
        chk("mid_rst_gnt", DW'(gnt), 0);
        chk("mid_rst_ack", DW'(ack), 0);
        repeat (2) @(negedge clk);
        push_exp(3'b010, 1'b1, V1);
        R = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt", DW'(gnt), 3'b010);
        chk("post_rst_mem_en", DW'(mem_en), 1);
        req = 3'b000;
        wait_idle();

        repeat (3) @(negedge clk);
        chk("queue_drained", DW'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
